// File: rtl/addcmp_rr_sched.sv
// Round-robin scheduler sharing one offset-add / signed threshold-compare pipeline (S1 latch, S2 result).
// Optional: define ADDCMP_STATS_EN to add the done_cnt completed-handshake counter port.
module addcmp_rr_sched #(
  parameter int NREQ  = 3,
  parameter int OP_W  = 3,
  parameter int OFF_W = 2,
  parameter int SUM_W = 5,
  parameter int ID_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*OP_W-1:0]    req_a,
  input  logic [NREQ*SUM_W-1:0]   req_thr,
  input  logic [OFF_W-1:0]        offset,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [SUM_W-1:0]        res_sum,
  output logic                    res_flag,
`ifdef ADDCMP_STATS_EN
  output logic [7:0]              done_cnt,
`endif
  output logic [ID_W-1:0]         res_id
);

  logic [ID_W-1:0]  r_ptr;
  logic             r_s1_v;
  logic [OP_W-1:0]  r_s1_a;
  logic [SUM_W-1:0] r_s1_thr;
  logic [OFF_W-1:0] r_s1_off;
  logic [ID_W-1:0]  r_s1_id;
  logic             r_s2_v;
  logic [SUM_W-1:0] r_s2_sum;
  logic             r_s2_flag;
  logic [ID_W-1:0]  r_s2_id;

  logic             w_s2_adv, w_s1_load, w_found, w_accept, w_flag;
  logic [ID_W-1:0]  w_win, w_ptr_nxt;
  logic [OP_W-1:0]  w_sel_a;
  logic [SUM_W-1:0] w_sel_thr, w_a_ext, w_off_ext, w_sum;

  assign w_s2_adv  = r_s1_v && (!r_s2_v || res_ready);
  assign w_s1_load = !r_s1_v || w_s2_adv;
  assign w_accept  = w_found && w_s1_load;

  // Rotating priority search starting at r_ptr; only req_valid feeds the grant.
  always_comb begin : arb
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    w_sel_a   = '0;
    w_sel_thr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == ID_W'(i)) begin
        req_ready[i] = w_accept;
        w_sel_a      = req_a[i*OP_W +: OP_W];
        w_sel_thr    = req_thr[i*SUM_W +: SUM_W];
      end
    end
  end

  assign w_ptr_nxt = (w_win == ID_W'(NREQ-1)) ? '0 : w_win + 1'b1;

  assign w_a_ext   = {{(SUM_W-OP_W){r_s1_a[OP_W-1]}}, r_s1_a};
  assign w_off_ext = {{(SUM_W-OFF_W){r_s1_off[OFF_W-1]}}, r_s1_off};
  assign w_sum     = w_a_ext + w_off_ext;
  assign w_flag    = $signed(w_sum) < $signed(r_s1_thr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_s1_v    <= 1'b0;
      r_s1_a    <= '0;
      r_s1_thr  <= '0;
      r_s1_off  <= '0;
      r_s1_id   <= '0;
      r_s2_v    <= 1'b0;
      r_s2_sum  <= '0;
      r_s2_flag <= 1'b0;
      r_s2_id   <= '0;
    end else begin
      if (w_accept) begin
        r_s1_a   <= w_sel_a;
        r_s1_thr <= w_sel_thr;
        r_s1_off <= offset;
        r_s1_id  <= w_win;
        r_ptr    <= w_ptr_nxt;
      end
      if (w_accept)      r_s1_v <= 1'b1;
      else if (w_s2_adv) r_s1_v <= 1'b0;
      // A reload on s2_adv wins over a pop in the same cycle, keeping res_valid high.
      if (w_s2_adv) begin
        r_s2_v    <= 1'b1;
        r_s2_sum  <= w_sum;
        r_s2_flag <= w_flag;
        r_s2_id   <= r_s1_id;
      end else if (res_ready) begin
        r_s2_v    <= 1'b0;
      end
    end
  end

  assign res_valid = r_s2_v;
  assign res_sum   = r_s2_sum;
  assign res_flag  = r_s2_flag;
  assign res_id    = r_s2_id;

`ifdef ADDCMP_STATS_EN
  logic [7:0] r_done_cnt;
  always_ff @(posedge clk) begin
    if (rst)                         r_done_cnt <= '0;
    else if (r_s2_v && res_ready)    r_done_cnt <= r_done_cnt + 8'd1;
  end
  assign done_cnt = r_done_cnt;
`endif

endmodule
